execute_cc_stage: RTL and testbench

- Sits directly downstream of the execute-stage ALU in the pipelined Y86 core.
- Holds the architectural condition-code register and loads it from the ALU's ZSO flags.
- Evaluates jump/cmov conditions against the stored flags and squashes the cmov destination.
- Latches the execute results into the E->M pipeline register, with stall and bubble control.

---
 rtl/execute_cc_stage.sv | 138 +++++++++++++
 tb/tb_execute_cc_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cc_stage.sv
// Execute-stage condition-code register, jump/cmov condition evaluation and
// E->M pipeline register for the pipelined Y86 core.
module execute_cc_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter logic [3:0]  RNONE    = 4'hF,
  parameter logic [2:0]  CC_RESET = 3'b100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        e_stat,
  input  logic [3:0]        e_icode,
  input  logic [3:0]        e_ifun,
  input  logic [2:0]        e_zso,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [DATA_W-1:0] e_valA,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        e_dstM,
  input  logic              cc_block,
  input  logic              m_stall,
  input  logic              m_bubble,
  output logic [2:0]        cc,
  output logic              e_cnd,
  output logic [3:0]        e_dstE_fwd,
  output logic [2:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);

  localparam logic [3:0] IcodeNop  = 4'h1;
  localparam logic [3:0] IcodeCmov = 4'h2;
  localparam logic [3:0] IcodeOpl  = 4'h6;
  localparam logic [2:0] StatAok   = 3'd1;

  logic [2:0]        r_cc;
  logic [2:0]        r_m_stat;
  logic [3:0]        r_m_icode;
  logic              r_m_cnd;
  logic [DATA_W-1:0] r_m_valE;
  logic [DATA_W-1:0] r_m_valA;
  logic [3:0]        r_m_dstE;
  logic [3:0]        r_m_dstM;

  logic w_z;
  logic w_s;
  logic w_o;
  logic w_lt;
  logic w_cnd;
  logic w_cc_we;

  assign w_z = r_cc[2];
  assign w_s = r_cc[1];
  assign w_o = r_cc[0];
  // Signed less-than after a compare is S xor O.
  assign w_lt = w_s ^ w_o;

  // OPL flags are only committed when no later stage has faulted and M is moving.
  assign w_cc_we = (e_icode == IcodeOpl) && !cc_block && !m_stall;

  // Condition decode from the stored flags; the current OPL never sees its own flags.
  always_comb begin
    w_cnd = 1'b0;
    case (e_ifun)
      4'h0:    w_cnd = 1'b1;
      4'h1:    w_cnd = w_lt | w_z;
      4'h2:    w_cnd = w_lt;
      4'h3:    w_cnd = w_z;
      4'h4:    w_cnd = ~w_z;
      4'h5:    w_cnd = ~w_lt;
      4'h6:    w_cnd = ~w_lt & ~w_z;
      default: w_cnd = 1'b0;
    endcase
  end

  assign e_cnd = w_cnd;

  // A failed cmov must not write its destination, so hide it from forwarding too.
  assign e_dstE_fwd = ((e_icode == IcodeCmov) && !w_cnd) ? RNONE : e_dstE;

  // Condition-code register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cc <= CC_RESET;
    end else if (w_cc_we) begin
      r_cc <= e_zso;
    end
  end

  // E->M pipeline register; stall has priority over bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_stat  <= StatAok;
      r_m_icode <= IcodeNop;
      r_m_cnd   <= 1'b0;
      r_m_valE  <= '0;
      r_m_valA  <= '0;
      r_m_dstE  <= RNONE;
      r_m_dstM  <= RNONE;
    end else if (m_stall) begin
      r_m_stat  <= r_m_stat;
      r_m_icode <= r_m_icode;
      r_m_cnd   <= r_m_cnd;
      r_m_valE  <= r_m_valE;
      r_m_valA  <= r_m_valA;
      r_m_dstE  <= r_m_dstE;
      r_m_dstM  <= r_m_dstM;
    end else if (m_bubble) begin
      r_m_stat  <= StatAok;
      r_m_icode <= IcodeNop;
      r_m_cnd   <= 1'b0;
      r_m_valE  <= '0;
      r_m_valA  <= '0;
      r_m_dstE  <= RNONE;
      r_m_dstM  <= RNONE;
    end else begin
      r_m_stat  <= e_stat;
      r_m_icode <= e_icode;
      r_m_cnd   <= w_cnd;
      r_m_valE  <= e_valE;
      r_m_valA  <= e_valA;
      r_m_dstE  <= e_dstE_fwd;
      r_m_dstM  <= e_dstM;
    end
  end

  assign cc      = r_cc;
  assign M_stat  = r_m_stat;
  assign M_icode = r_m_icode;
  assign M_cnd   = r_m_cnd;
  assign M_valE  = r_m_valE;
  assign M_valA  = r_m_valA;
  assign M_dstE  = r_m_dstE;
  assign M_dstM  = r_m_dstM;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Self-checking bench for execute_cc_stage: directed steps then random traffic,
// all compared against a behavioural model of the CC register and M register.
module tb_execute_cc_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    e_stat;
  logic [3:0]    e_icode;
  logic [3:0]    e_ifun;
  logic [2:0]    e_zso;
  logic [DW-1:0] e_valE;
  logic [DW-1:0] e_valA;
  logic [3:0]    e_dstE;
  logic [3:0]    e_dstM;
  logic          cc_block;
  logic          m_stall;
  logic          m_bubble;
  logic [2:0]    cc;
  logic          e_cnd;
  logic [3:0]    e_dstE_fwd;
  logic [2:0]    M_stat;
  logic [3:0]    M_icode;
  logic          M_cnd;
  logic [DW-1:0] M_valE;
  logic [DW-1:0] M_valA;
  logic [3:0]    M_dstE;
  logic [3:0]    M_dstM;

  execute_cc_stage dut (
    .clk        (clk),
    .reset      (reset),
    .e_stat     (e_stat),
    .e_icode    (e_icode),
    .e_ifun     (e_ifun),
    .e_zso      (e_zso),
    .e_valE     (e_valE),
    .e_valA     (e_valA),
    .e_dstE     (e_dstE),
    .e_dstM     (e_dstM),
    .cc_block   (cc_block),
    .m_stall    (m_stall),
    .m_bubble   (m_bubble),
    .cc         (cc),
    .e_cnd      (e_cnd),
    .e_dstE_fwd (e_dstE_fwd),
    .M_stat     (M_stat),
    .M_icode    (M_icode),
    .M_cnd      (M_cnd),
    .M_valE     (M_valE),
    .M_valA     (M_valA),
    .M_dstE     (M_dstE),
    .M_dstM     (M_dstM)
  );

  always #5 clk = ~clk;

  // Stall and bubble together is legal but suspicious; stall takes priority.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(m_stall && m_bubble))
        else $warning("m_stall and m_bubble both high; M register holds");
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  // Model state.
  logic [2:0]    mdl_cc;
  logic [2:0]    mdl_stat;
  logic [3:0]    mdl_icode;
  logic          mdl_cnd;
  logic [DW-1:0] mdl_valE;
  logic [DW-1:0] mdl_valA;
  logic [3:0]    mdl_dstE;
  logic [3:0]    mdl_dstM;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Branch condition from its meaning: signed compare of the last OPL result with zero.
  function automatic logic ref_cond(input logic [2:0] flags, input int fn);
    bit zero, neg_result;
    zero       = (flags[2] == 1'b1);
    neg_result = (flags[1] != flags[0]);
    if (fn == 0) return 1'b1;
    if (fn == 1) return neg_result || zero;
    if (fn == 2) return neg_result;
    if (fn == 3) return zero;
    if (fn == 4) return !zero;
    if (fn == 5) return !neg_result;
    if (fn == 6) return !neg_result && !zero;
    return 1'b0;
  endfunction

  task automatic model_bubble();
    mdl_stat  = 3'd1;
    mdl_icode = 4'h1;
    mdl_cnd   = 1'b0;
    mdl_valE  = '0;
    mdl_valA  = '0;
    mdl_dstE  = 4'hF;
    mdl_dstM  = 4'hF;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic step();
    logic       ecnd;
    logic [3:0] efwd;
    #1;
    ecnd = ref_cond(mdl_cc, int'(e_ifun));
    efwd = (e_icode == 4'h2 && !ecnd) ? 4'hF : e_dstE;
    if (!reset) begin
      chk("e_cnd", DW'(e_cnd), DW'(ecnd));
      chk("e_dstE_fwd", DW'(e_dstE_fwd), DW'(efwd));
    end
    if (reset) begin
      mdl_cc = 3'b100;
      model_bubble();
    end else begin
      if (e_icode == 4'h6 && !cc_block && !m_stall) mdl_cc = e_zso;
      if (m_stall) begin
        // hold
      end else if (m_bubble) begin
        model_bubble();
      end else begin
        mdl_stat  = e_stat;
        mdl_icode = e_icode;
        mdl_cnd   = ecnd;
        mdl_valE  = e_valE;
        mdl_valA  = e_valA;
        mdl_dstE  = efwd;
        mdl_dstM  = e_dstM;
      end
    end
    @(posedge clk);
    #1;
    chk("cc", DW'(cc), DW'(mdl_cc));
    chk("M_stat", DW'(M_stat), DW'(mdl_stat));
    chk("M_icode", DW'(M_icode), DW'(mdl_icode));
    chk("M_cnd", DW'(M_cnd), DW'(mdl_cnd));
    chk("M_valE", M_valE, mdl_valE);
    chk("M_valA", M_valA, mdl_valA);
    chk("M_dstE", DW'(M_dstE), DW'(mdl_dstE));
    chk("M_dstM", DW'(M_dstM), DW'(mdl_dstM));
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun, input logic [2:0] zso,
                       input logic [DW-1:0] vale, input logic [3:0] dste);
    e_stat  = 3'd1;
    e_icode = icode;
    e_ifun  = ifun;
    e_zso   = zso;
    e_valE  = vale;
    e_valA  = 32'hA5A5_0000 ^ vale;
    e_dstE  = dste;
    e_dstM  = 4'hF;
  endtask

  initial begin
    mdl_cc = 3'b100;
    model_bubble();
    reset = 1'b1; cc_block = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with an OPL presenting flags: CC must not load.
    drive(4'h6, 4'h0, 3'b011, 32'h1234, 4'h2);
    step();
    step();
    chk("reset_cc", DW'(cc), DW'(3'b100));
    chk("reset_M_icode", DW'(M_icode), DW'(4'h1));
    chk("reset_M_dstE", DW'(M_dstE), DW'(4'hF));
    reset = 1'b0;

    // OPL writes flags; next jl sees S^O = 1.
    drive(4'h6, 4'h0, 3'b010, 32'hFFFF_FFFE, 4'h2);
    step();
    chk("opl_cc", DW'(cc), DW'(3'b010));
    chk("opl_valE", M_valE, 32'hFFFF_FFFE);
    drive(4'h7, 4'h2, 3'b000, 32'h0, 4'hF);
    step();
    chk("jl_M_cnd", DW'(M_cnd), DW'(1'b1));

    // cmov squash with cc = 000.
    drive(4'h6, 4'h0, 3'b000, 32'h5, 4'h1);
    step();
    drive(4'h2, 4'h3, 3'b111, 32'h7, 4'h3);
    #1;
    chk("cmove_cnd", DW'(e_cnd), DW'(1'b0));
    chk("cmove_fwd", DW'(e_dstE_fwd), DW'(4'hF));
    step();
    chk("cmove_M_dstE", DW'(M_dstE), DW'(4'hF));
    e_ifun = 4'h4;
    step();
    chk("cmovne_M_dstE", DW'(M_dstE), DW'(4'h3));

    // cc_block inhibits the OPL write.
    drive(4'h6, 4'h0, 3'b100, 32'h0, 4'h1);
    step();
    drive(4'h6, 4'h6, 3'b001, 32'h9, 4'h1);
    cc_block = 1'b1;
    #1;
    chk("g_cnd_blocked", DW'(e_cnd), DW'(1'b0));
    step();
    chk("blocked_cc", DW'(cc), DW'(3'b100));
    cc_block = 1'b0;

    // Stall beats bubble, then bubble alone clears M.
    drive(4'h5, 4'h0, 3'b000, 32'h10, 4'hF);
    e_dstM = 4'h4;
    step();
    drive(4'h6, 4'h1, 3'b011, 32'hDEAD_BEEF, 4'h6);
    m_stall = 1'b1; m_bubble = 1'b1;
    step();
    step();
    chk("stall_icode", DW'(M_icode), DW'(4'h5));
    chk("stall_valE", M_valE, 32'h10);
    chk("stall_cc", DW'(cc), DW'(3'b100));
    m_stall = 1'b0;
    step();
    chk("bubble_icode", DW'(M_icode), DW'(4'h1));
    chk("bubble_dstE", DW'(M_dstE), DW'(4'hF));
    m_bubble = 1'b0;

    // Condition table sweep over all stored flag values.
    for (int f = 0; f < 8; f++) begin
      drive(4'h6, 4'h0, 3'(f), 32'(f), 4'h1);
      step();
      for (int fn = 0; fn < 8; fn++) begin
        drive(4'h7, 4'(fn), 3'b000, 32'h0, 4'hF);
        step();
      end
      e_ifun = 4'h7;
      #1;
      chk("ifun7_zero", DW'(e_cnd), DW'(1'b0));
    end

    // Random traffic, including high ifun codes and occasional mid-run reset.
    for (int i = 0; i < 400; i++) begin
      e_stat   = 3'($urandom_range(1, 4));
      e_icode  = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      e_ifun   = 4'($urandom_range(0, 15));
      e_zso    = 3'($urandom);
      e_valE   = $urandom;
      e_valA   = $urandom;
      e_dstE   = 4'($urandom);
      e_dstM   = 4'($urandom);
      cc_block = ($urandom_range(0, 7) == 0);
      m_stall  = ($urandom_range(0, 7) == 0);
      m_bubble = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
